// File: rtl/gw4302_dma_sequencer.sv
// REU-style DMA sequencer: moves bytes between C64 bus and REU RAM, one per available PHI2 cycle.
// Supports stash, fetch, swap (two cycles per byte) and verify, with BA stall handling and autoload.
module gw4302_dma_sequencer #(
  parameter int REU_AW = 19
) (
  input  logic              i_phi2,
  input  logic              i_reset,
  input  logic              i_execute,
  input  logic [1:0]        i_cmd,
  input  logic [15:0]       i_c64_start,
  input  logic [REU_AW-1:0] i_reu_start,
  input  logic [15:0]       i_len_start,
  input  logic              i_fix_c64,
  input  logic              i_fix_reu,
  input  logic              i_autoload,
  input  logic              i_ba,
  input  logic              i_verify_eq,
  output logic              o_dma,
  output logic              o_dmarw,
  output logic [15:0]       o_c64_addr,
  output logic [REU_AW-1:0] o_reu_addr,
  output logic [15:0]       o_len_cur,
  output logic              o_ram_oe,
  output logic              o_ram_we,
  output logic              o_latch_c64,
  output logic              o_latch_ram,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_verify_err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_XFER, S_SWAP2, S_END} state_t;

  localparam logic [1:0] CMD_STASH  = 2'b00;
  localparam logic [1:0] CMD_FETCH  = 2'b01;
  localparam logic [1:0] CMD_SWAP   = 2'b10;
  localparam logic [1:0] CMD_VERIFY = 2'b11;
  localparam logic [REU_AW-1:0] REU_ONE = {{(REU_AW-1){1'b0}}, 1'b1};

  state_t            r_state, w_next;
  logic [1:0]        r_cmd;
  logic              r_fix_c64, r_fix_reu, r_autoload;
  logic [15:0]       r_c64_addr, r_len;
  logic [REU_AW-1:0] r_reu_addr;
  logic              r_dma, r_verify_err;

  logic w_dmarw, w_ram_oe, w_ram_we, w_latch_c64, w_latch_ram;
  logic w_advance, w_stop;

  always_comb begin
    w_next      = r_state;
    w_dmarw     = 1'b1;
    w_ram_oe    = 1'b0;
    w_ram_we    = 1'b0;
    w_latch_c64 = 1'b0;
    w_latch_ram = 1'b0;
    w_advance   = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      S_IDLE: if (i_execute) w_next = S_ARM;
      S_ARM:  if (i_ba) w_next = S_XFER;
      S_XFER: begin
        if (i_ba) begin
          case (r_cmd)
            CMD_STASH: begin
              w_ram_we  = 1'b1;
              w_advance = 1'b1;
            end
            CMD_FETCH: begin
              w_dmarw   = 1'b0;
              w_ram_oe  = 1'b1;
              w_advance = 1'b1;
            end
            CMD_SWAP: begin
              w_ram_oe    = 1'b1;
              w_latch_c64 = 1'b1;
              w_latch_ram = 1'b1;
              w_next      = S_SWAP2;
            end
            CMD_VERIFY: begin
              w_ram_oe  = 1'b1;
              w_advance = 1'b1;
              w_stop    = ~i_verify_eq;
            end
            default: ;
          endcase
        end
      end
      S_SWAP2: begin
        if (i_ba) begin
          w_dmarw   = 1'b0;
          w_ram_we  = 1'b1;
          w_advance = 1'b1;
          w_next    = S_XFER;
        end
      end
      S_END:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // last byte or verify mismatch ends the transfer after this byte
    if (w_advance && ((r_len == 16'd1) || w_stop)) w_next = S_END;
  end

  always_ff @(posedge i_phi2) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_dma   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dma   <= (w_next == S_ARM) || (w_next == S_XFER) || (w_next == S_SWAP2);
    end
  end

  always_ff @(posedge i_phi2) begin
    if (i_reset) begin
      r_cmd        <= CMD_STASH;
      r_fix_c64    <= 1'b0;
      r_fix_reu    <= 1'b0;
      r_autoload   <= 1'b0;
      r_c64_addr   <= 16'd0;
      r_reu_addr   <= '0;
      r_len        <= 16'd0;
      r_verify_err <= 1'b0;
    end else if (r_state == S_IDLE && i_execute) begin
      r_cmd        <= i_cmd;
      r_fix_c64    <= i_fix_c64;
      r_fix_reu    <= i_fix_reu;
      r_autoload   <= i_autoload;
      r_c64_addr   <= i_c64_start;
      r_reu_addr   <= i_reu_start;
      r_len        <= i_len_start;
      r_verify_err <= 1'b0;
    end else if (w_advance) begin
      if (!r_fix_c64) r_c64_addr <= r_c64_addr + 16'd1;
      if (!r_fix_reu) r_reu_addr <= r_reu_addr + REU_ONE;
      // length 0 means 65536 and wraps naturally to FFFF
      if (r_len != 16'd1) r_len <= r_len - 16'd1;
      if (w_stop) r_verify_err <= 1'b1;
    end else if (r_state == S_END && r_autoload) begin
      r_c64_addr <= i_c64_start;
      r_reu_addr <= i_reu_start;
      r_len      <= i_len_start;
    end
  end

  assign o_dma        = r_dma;
  assign o_dmarw      = w_dmarw;
  assign o_c64_addr   = r_c64_addr;
  assign o_reu_addr   = r_reu_addr;
  assign o_len_cur    = r_len;
  assign o_ram_oe     = w_ram_oe;
  assign o_ram_we     = w_ram_we;
  assign o_latch_c64  = w_latch_c64;
  assign o_latch_ram  = w_latch_ram;
  assign o_busy       = (r_state == S_ARM) || (r_state == S_XFER) || (r_state == S_SWAP2);
  assign o_done       = (r_state == S_END);
  assign o_verify_err = r_verify_err;

endmodule

// File: tb/tb_gw4302_dma_sequencer.sv
// Directed bench for gw4302_dma_sequencer: inputs change just after the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_gw4302_dma_sequencer;

  logic        i_phi2 = 1'b0;
  logic        i_reset, i_execute, i_fix_c64, i_fix_reu, i_autoload, i_ba, i_verify_eq;
  logic [1:0]  i_cmd;
  logic [15:0] i_c64_start, i_len_start;
  logic [18:0] i_reu_start;
  logic        o_dma, o_dmarw, o_ram_oe, o_ram_we, o_latch_c64, o_latch_ram;
  logic        o_busy, o_done, o_verify_err;
  logic [15:0] o_c64_addr, o_len_cur;
  logic [18:0] o_reu_addr;

  int checks = 0;
  int errors = 0;

  always #5 i_phi2 = ~i_phi2;

  gw4302_dma_sequencer #(.REU_AW(19)) dut (
    .i_phi2(i_phi2), .i_reset(i_reset), .i_execute(i_execute), .i_cmd(i_cmd),
    .i_c64_start(i_c64_start), .i_reu_start(i_reu_start), .i_len_start(i_len_start),
    .i_fix_c64(i_fix_c64), .i_fix_reu(i_fix_reu), .i_autoload(i_autoload),
    .i_ba(i_ba), .i_verify_eq(i_verify_eq),
    .o_dma(o_dma), .o_dmarw(o_dmarw), .o_c64_addr(o_c64_addr), .o_reu_addr(o_reu_addr),
    .o_len_cur(o_len_cur), .o_ram_oe(o_ram_oe), .o_ram_we(o_ram_we),
    .o_latch_c64(o_latch_c64), .o_latch_ram(o_latch_ram),
    .o_busy(o_busy), .o_done(o_done), .o_verify_err(o_verify_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe bundle {dma, dmarw, oe, we, latch_c64, latch_ram, busy, done}
  function automatic logic [7:0] ctl();
    return {o_dma, o_dmarw, o_ram_oe, o_ram_we, o_latch_c64, o_latch_ram, o_busy, o_done};
  endfunction

  task automatic step();
    @(negedge i_phi2);
  endtask

  task automatic start(input logic [1:0] cmd, input logic [15:0] c64, input logic [18:0] reu,
                       input logic [15:0] len, input logic fc, input logic fr, input logic al);
    i_cmd = cmd; i_c64_start = c64; i_reu_start = reu; i_len_start = len;
    i_fix_c64 = fc; i_fix_reu = fr; i_autoload = al; i_execute = 1'b1;
    step();
    i_execute = 1'b0;
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_execute = 1'b0; i_cmd = 2'b00; i_c64_start = 16'h0; i_reu_start = 19'h0;
    i_len_start = 16'h0; i_fix_c64 = 1'b0; i_fix_reu = 1'b0; i_autoload = 1'b0;
    i_ba = 1'b1; i_verify_eq = 1'b1;
    step(); step(); step();
    #1;
    chk("reset_ctl", ctl(), 8'b0100_0000);
    chk("reset_c64", o_c64_addr, 16'h0);
    chk("reset_reu", o_reu_addr, 19'h0);
    chk("reset_len", o_len_cur, 16'h0);
    chk("reset_verr", o_verify_err, 1'b0);
    i_reset = 1'b0;

    // stash 3 bytes from 1000h
    step(); #1;
    start(2'b00, 16'h1000, 19'h0, 16'd3, 1'b0, 1'b0, 1'b0);
    chk("stash_arm_ctl", ctl(), 8'b1100_0010);
    chk("stash_arm_c64", o_c64_addr, 16'h1000);
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("stash_byte_ctl", ctl(), 8'b1101_0010);
      chk("stash_byte_c64", o_c64_addr, 16'h1000 + 16'(k));
    end
    step(); #1;
    chk("stash_end_ctl", ctl(), 8'b0100_0001);
    chk("stash_end_c64", o_c64_addr, 16'h1003);
    chk("stash_end_reu", o_reu_addr, 19'h3);
    chk("stash_end_len", o_len_cur, 16'd1);
    step(); #1;
    chk("stash_idle_ctl", ctl(), 8'b0100_0000);

    // fetch 2 bytes, BA low for two cycles after the first byte
    start(2'b01, 16'h2000, 19'h10, 16'd2, 1'b0, 1'b0, 1'b0);
    chk("fetch_arm_ctl", ctl(), 8'b1100_0010);
    step(); #1;
    chk("fetch_b1_ctl", ctl(), 8'b1010_0010);
    chk("fetch_b1_c64", o_c64_addr, 16'h2000);
    step(); i_ba = 1'b0; #1;
    chk("fetch_stall1_ctl", ctl(), 8'b1100_0010);
    chk("fetch_stall1_c64", o_c64_addr, 16'h2001);
    step(); #1;
    chk("fetch_stall2_ctl", ctl(), 8'b1100_0010);
    chk("fetch_stall2_reu", o_reu_addr, 19'h11);
    chk("fetch_stall2_len", o_len_cur, 16'd1);
    step(); i_ba = 1'b1; #1;
    chk("fetch_b2_ctl", ctl(), 8'b1010_0010);
    chk("fetch_b2_c64", o_c64_addr, 16'h2001);
    step(); #1;
    chk("fetch_end_ctl", ctl(), 8'b0100_0001);
    chk("fetch_end_c64", o_c64_addr, 16'h2002);
    chk("fetch_end_reu", o_reu_addr, 19'h12);
    step(); #1;

    // swap 1 byte
    start(2'b10, 16'h3000, 19'h20, 16'd1, 1'b0, 1'b0, 1'b0);
    step(); #1;
    chk("swap_rd_ctl", ctl(), 8'b1110_1110);
    step(); #1;
    chk("swap_wr_ctl", ctl(), 8'b1001_0010);
    chk("swap_wr_c64", o_c64_addr, 16'h3000);
    step(); #1;
    chk("swap_end_ctl", ctl(), 8'b0100_0001);
    chk("swap_end_c64", o_c64_addr, 16'h3001);
    step(); #1;

    // verify 4 bytes, mismatch on byte 2
    start(2'b11, 16'h4000, 19'h30, 16'd4, 1'b0, 1'b0, 1'b0);
    step(); #1;
    chk("verify_b1_ctl", ctl(), 8'b1110_0010);
    step(); i_verify_eq = 1'b0; #1;
    chk("verify_b2_ctl", ctl(), 8'b1110_0010);
    step(); i_verify_eq = 1'b1; #1;
    chk("verify_end_ctl", ctl(), 8'b0100_0001);
    chk("verify_err", o_verify_err, 1'b1);
    chk("verify_len", o_len_cur, 16'd2);
    chk("verify_c64", o_c64_addr, 16'h4002);
    step(); #1;
    chk("verify_err_sticky", o_verify_err, 1'b1);

    // fetch with REU wrap, fixed C64 address, autoload
    start(2'b01, 16'h5000, 19'h7FFFF, 16'd2, 1'b1, 1'b0, 1'b1);
    chk("auto_verr_clr", o_verify_err, 1'b0);
    step(); #1;
    chk("auto_b1_reu", o_reu_addr, 19'h7FFFF);
    chk("auto_b1_c64", o_c64_addr, 16'h5000);
    step(); #1;
    chk("auto_b2_reu", o_reu_addr, 19'h00000);
    chk("auto_b2_c64", o_c64_addr, 16'h5000);
    step(); #1;
    chk("auto_end_ctl", ctl(), 8'b0100_0001);
    step(); #1;
    chk("auto_idle_c64", o_c64_addr, 16'h5000);
    chk("auto_idle_reu", o_reu_addr, 19'h7FFFF);
    chk("auto_idle_len", o_len_cur, 16'd2);

    // length 0 stash, reset on byte 10
    start(2'b00, 16'h6000, 19'h0, 16'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    #1;
    chk("len0_b10_c64", o_c64_addr, 16'h6009);
    chk("len0_b10_len", o_len_cur, 16'hFFF7);
    chk("len0_b10_ctl", ctl(), 8'b1101_0010);
    i_execute = 1'b1; i_reset = 1'b1;
    step(); i_reset = 1'b0; i_execute = 1'b0; #1;
    chk("abort_ctl", ctl(), 8'b0100_0000);
    chk("abort_c64", o_c64_addr, 16'h0);
    chk("abort_len", o_len_cur, 16'h0);
    step(); #1;
    chk("abort_no_done", ctl(), 8'b0100_0000);

    start(2'b00, 16'h7000, 19'h40, 16'd1, 1'b0, 1'b0, 1'b0);
    chk("fresh_arm_ctl", ctl(), 8'b1100_0010);
    step(); #1;
    chk("fresh_b1_c64", o_c64_addr, 16'h7000);
    step(); #1;
    chk("fresh_end_ctl", ctl(), 8'b0100_0001);
    chk("fresh_end_reu", o_reu_addr, 19'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gw4302_dma_sequencer.md
GW4302_DMA_SEQUENCER -- requirements
Module: gw4302_dma_sequencer

Interface
REQ-001 Parameter: REU_AW, default 19, REU RAM address width; 512 KB.
REQ-002 PHI2  in  1  sole clock; one C64 bus cycle per rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Execute  in  1  start pulse from register/decode logic.
REQ-005 Cmd  in  2  00 stash (C64->REU), 01 fetch (REU->C64), 10 swap, 11 verify.
REQ-006 C64Start  in  16  C64 start address.
REQ-007 REUStart  in  REU_AW  REU start address.
REQ-008 LenStart  in  16  transfer length; 0 means 65536.
REQ-009 FixC64, FixREU, Autoload  in  1 each  hold C64 address; hold REU address; restore start values at end.
REQ-010 BA  in  1  bus available from C64; 0 means VIC owns the cycle.
REQ-011 VerifyEq  in  1  external compare of C64 byte vs RAM byte, valid in verify cycles.
REQ-012 DMA  out  1  request C64 bus.
REQ-013 DMARW  out  1  1 = C64 read cycle, 0 = C64 write cycle.
REQ-014 C64Addr  out  16  current C64 address.
REQ-015 REUAddr  out  REU_AW  current REU address.
REQ-016 LenCur  out  16  current length counter.
REQ-017 RamOE, RamWE  out  1 each  REU RAM read / write strobes.
REQ-018 LatchC64, LatchRam  out  1 each  capture C64 bus byte / RAM byte into swap latches.
REQ-019 Busy, Done, VerifyErr  out  1 each  transfer active; one-cycle end pulse; sticky verify mismatch.

Function
REQ-020 States SHALL be IDLE, ARM, XFER, SWAP2, END.
REQ-021 IDLE, Execute=1: load C64Addr/REUAddr/LenCur from start inputs, latch Cmd/Fix/Autoload, clear VerifyErr, go ARM; Busy=1 from next cycle.
REQ-022 Execute SHALL be ignored outside IDLE.
REQ-023 DMA SHALL be registered and 1 in ARM, XFER, SWAP2; 0 in IDLE, END.
REQ-024 ARM: go XFER on first edge with BA=1; no strobes.
REQ-025 Active cycle = XFER or SWAP2 with BA=1; when BA=0, strobes, LatchC64/LatchRam, counters, and state SHALL hold.
REQ-026 Stash active cycle: DMARW=1, RamWE=1.
REQ-027 Fetch active cycle: DMARW=0, RamOE=1.
REQ-028 Swap XFER active cycle: DMARW=1, RamOE=1, LatchC64=1, LatchRam=1, go SWAP2 without advancing.
REQ-029 Swap SWAP2 active cycle: DMARW=0, RamWE=1, then advance.
REQ-030 Verify active cycle: DMARW=1, RamOE=1, sample VerifyEq.
REQ-031 In XFER/SWAP2 when not active, DMARW SHALL be 1 and all strobes 0.
REQ-032 Advance SHALL occur at the end of each completed byte:
  - C64Addr+1 mod 2^16 unless FixC64.
  - REUAddr+1 mod 2^REU_AW unless FixREU.
  - If LenCur==1: go END, LenCur stays 1.
  - Else LenCur-1, with 0 -> FFFF.
REQ-033 Verify mismatch (VerifyEq=0) SHALL set VerifyErr, advance addresses and go END after that byte.
REQ-034 END, one cycle: Done=1, Busy=0, DMA=0.
  - Autoload: restore C64Addr/REUAddr/LenCur from start inputs.
  - Otherwise: keep final values.
  - Go IDLE.
REQ-035 Strobes and latch outputs SHALL be combinational from state, Cmd, BA; no glitch on state hold.

Reset
REQ-036 Reset SHALL win over Execute and abort any state to IDLE at that edge.
REQ-037 Reset values: DMA=0, DMARW=1, C64Addr=0, REUAddr=0, LenCur=0, VerifyErr=0, Busy=0, Done=0, all strobes 0.
REQ-038 Reset mid-transfer SHALL NOT produce Done.

Verification
REQ-039 Stash, C64Start=1000h, REUStart=0, Len=3, BA=1:
  - DMA=1 the cycle after Execute.
  - RamWE in 3 cycles at C64Addr 1000h/1001h/1002h.
  - Done pulse; final C64Addr=1003h, REUAddr=3, LenCur=1.
REQ-040 Fetch, Len=2, BA=0 for 2 cycles after the first byte: RamOE/DMARW=0 only on BA=1 cycles, addresses frozen during the stall, 2 bytes total.
REQ-041 Swap, Len=1: cycle with DMARW=1 and LatchC64/LatchRam, then a cycle with DMARW=0 and RamWE, then Done.
REQ-042 Verify, Len=4, VerifyEq=0 on byte 2: VerifyErr=1, Done after byte 2, LenCur=2, C64Addr=start+2.
REQ-043 Fetch, REUStart=7FFFFh, Len=2, FixC64=1, Autoload=1: REUAddr sequence 7FFFFh then 00000h, C64Addr constant; after Done all registers equal the start inputs.
REQ-044 Len=0 stash, Reset asserted at byte 10: next cycle DMA=0, state IDLE, counters 0, no Done; a subsequent Execute starts a fresh transfer.
